maq_enchimento: RTL and testbench

- Filling-station controller directly upstream of the conveyor belt controller.
- Receives the raw bottle-in-position sensor and produces the gated position signal PG_OUT, which drives the conveyor's PG input, so it decides when the belt holds a bottle and when it releases it.
- While the belt is held, it opens the fill valve until the level sensor trips or a timeout fires.
- It counts filled bottles per batch and raises alarm and batch-done flags.

---
 rtl/maq_enchimento_if.sv | 27 ++
 rtl/maq_enchimento.sv | 135 +++++++++++++
 tb/tb_maq_enchimento.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maq_enchimento_if.sv
// Signal bundle between the filling-station controller and its surroundings:
// sensors and operator acknowledge in, belt gating, valve and status flags out.
interface maq_enchimento_if #(
   parameter int CNT_W = 8
);
   logic             ST;
   logic             PG_IN;
   logic             NV;
   logic             M;
   logic             ACK;
   logic             PG_OUT;
   logic             EV;
   logic [CNT_W-1:0] COUNT;
   logic             BATCH_DONE;
   logic             ALARM;
   logic             BUSY;

   modport master (
      output ST, PG_IN, NV, M, ACK,
      input  PG_OUT, EV, COUNT, BATCH_DONE, ALARM, BUSY
   );

   modport slave (
      input  ST, PG_IN, NV, M, ACK,
      output PG_OUT, EV, COUNT, BATCH_DONE, ALARM, BUSY
   );
endinterface

// File: rtl/maq_enchimento.sv
// Filling-station controller sitting in front of the conveyor. It gates the
// bottle-position signal to hold the belt, lets the bottle settle, opens the
// fill valve until the level sensor trips (or a timeout raises an alarm),
// then releases the bottle and counts it towards the current batch.
module maq_enchimento #(
   parameter int SETTLE_CYC   = 4,
   parameter int FILL_TIMEOUT = 1000,
   parameter int RELEASE_CYC  = 50,
   parameter int BATCH_SIZE   = 12,
   parameter int CNT_W        = 8
) (
   input logic             clk,
   input logic             reset,
   maq_enchimento_if.slave busIf
);

   localparam int MAX_SF  = (SETTLE_CYC > FILL_TIMEOUT) ? SETTLE_CYC : FILL_TIMEOUT;
   localparam int MAX_CYC = (MAX_SF > RELEASE_CYC) ? MAX_SF : RELEASE_CYC;
   localparam int TIMER_W = $clog2(MAX_CYC + 1);

   localparam logic [TIMER_W-1:0] TIMER_ZERO   = '0;
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYC - 1);
   localparam logic [TIMER_W-1:0] FILL_LAST    = TIMER_W'(FILL_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] RELEASE_LAST = TIMER_W'(RELEASE_CYC - 1);
   localparam logic [CNT_W-1:0]   BATCH_FULL   = CNT_W'(BATCH_SIZE);
   localparam logic [CNT_W-1:0]   COUNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_FILL,
      S_RELEASE,
      S_ALARM,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // Next-state, timer and batch-count decisions; the timer is cleared on every state change
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (busIf.ST && busIf.PG_IN) begin
               state_d = S_SETTLE;
               timer_d = TIMER_ZERO;
            end
         end
         S_SETTLE: begin
            if (!busIf.PG_IN) begin
               state_d = S_IDLE;
               timer_d = TIMER_ZERO;
            end else if (busIf.M) begin
               timer_d = TIMER_ZERO;
            end else if (timer_q == SETTLE_LAST) begin
               state_d = S_FILL;
               timer_d = TIMER_ZERO;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         S_FILL: begin
            if (busIf.NV) begin
               state_d = S_RELEASE;
               timer_d = TIMER_ZERO;
               if (count_q < BATCH_FULL) begin
                  count_d = count_q + COUNT_ONE;
               end
            end else if (busIf.ST) begin
               if (timer_q == FILL_LAST) begin
                  state_d = S_ALARM;
                  timer_d = TIMER_ZERO;
               end else begin
                  timer_d = timer_q + TIMER_ONE;
               end
            end
         end
         S_RELEASE: begin
            if (timer_q == RELEASE_LAST) begin
               if (!busIf.PG_IN) begin
                  state_d = (count_q == BATCH_FULL) ? S_DONE : S_IDLE;
                  timer_d = TIMER_ZERO;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         S_ALARM: begin
            if (busIf.ACK) begin
               state_d = S_RELEASE;
               timer_d = TIMER_ZERO;
            end
         end
         S_DONE: begin
            if (busIf.ACK) begin
               state_d = S_IDLE;
               timer_d = TIMER_ZERO;
               count_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = TIMER_ZERO;
         end
      endcase
   end

   // State, timer and count registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= TIMER_ZERO;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         count_q <= count_d;
      end
   end

   // Outputs are decoded from the state register so reset drops them immediately;
   // the valve additionally follows ST so a system stop pauses the fill.
   assign busIf.PG_OUT     = (state_q == S_SETTLE) || (state_q == S_FILL) || (state_q == S_ALARM);
   assign busIf.EV         = (state_q == S_FILL) && busIf.ST;
   assign busIf.ALARM      = (state_q == S_ALARM);
   assign busIf.BATCH_DONE = (state_q == S_DONE);
   assign busIf.BUSY       = (state_q != S_IDLE);
   assign busIf.COUNT      = count_q;

endmodule

// File: tb/tb_maq_enchimento.sv
// Bench for the filling-station controller: directed scenarios followed by a
// randomized run, all compared against a bottle-lifecycle reference model.
module tb_maq_enchimento;

   localparam int SC    = 2;
   localparam int FT    = 10;
   localparam int RC    = 3;
   localparam int BS    = 2;
   localparam int CNT_W = 8;

   logic clk;
   logic reset;

   int assertCount;
   int failCount;

   // Reference model: which phase the current bottle is in, plus plain counters
   bit settling, filling, faulted, releasing, doneFlag;
   int settleRun, openCycles, releaseAge, bottles;

   maq_enchimento_if #(.CNT_W(CNT_W)) busIf ();

   maq_enchimento #(
      .SETTLE_CYC  (SC),
      .FILL_TIMEOUT(FT),
      .RELEASE_CYC (RC),
      .BATCH_SIZE  (BS),
      .CNT_W       (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .busIf(busIf)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      settling   = 0;
      filling    = 0;
      faulted    = 0;
      releasing  = 0;
      doneFlag   = 0;
      settleRun  = 0;
      openCycles = 0;
      releaseAge = 0;
      bottles    = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge
   task automatic modelStep();
      if (doneFlag) begin
         if (busIf.ACK) begin
            doneFlag = 0;
            bottles  = 0;
         end
      end else if (faulted) begin
         if (busIf.ACK) begin
            faulted    = 0;
            releasing  = 1;
            releaseAge = 0;
         end
      end else if (releasing) begin
         if (releaseAge >= RC - 1) begin
            if (!busIf.PG_IN) begin
               releasing = 0;
               if (bottles == BS) doneFlag = 1;
            end
         end else begin
            releaseAge++;
         end
      end else if (filling) begin
         if (busIf.NV) begin
            filling    = 0;
            releasing  = 1;
            releaseAge = 0;
            if (bottles < BS) bottles++;
         end else if (busIf.ST) begin
            openCycles++;
            if (openCycles == FT) begin
               filling = 0;
               faulted = 1;
            end
         end
      end else if (settling) begin
         if (!busIf.PG_IN) begin
            settling = 0;
         end else if (busIf.M) begin
            settleRun = 0;
         end else begin
            settleRun++;
            if (settleRun == SC) begin
               settling   = 0;
               filling    = 1;
               openCycles = 0;
            end
         end
      end else begin
         if (busIf.ST && busIf.PG_IN) begin
            settling  = 1;
            settleRun = 0;
         end
      end
   endtask

   task automatic checkOutput();
      logic holding;
      logic busyExp;
      holding = settling | filling | faulted;
      busyExp = settling | filling | faulted | releasing | doneFlag;
      checkVal("pg_out",     busIf.PG_OUT,     holding);
      checkVal("ev",         busIf.EV,         filling & busIf.ST);
      checkVal("alarm",      busIf.ALARM,      faulted);
      checkVal("batch_done", busIf.BATCH_DONE, doneFlag);
      checkVal("busy",       busIf.BUSY,       busyExp);
      checkVal("count",      busIf.COUNT,      bottles);
      checkVal("ev_without_hold", busIf.EV & ~busIf.PG_OUT, 1'b0);
   endtask

   task automatic applyStimulus(input logic st, input logic pg, input logic nv,
                                input logic m, input logic ack);
      busIf.ST    = st;
      busIf.PG_IN = pg;
      busIf.NV    = nv;
      busIf.M     = m;
      busIf.ACK   = ack;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (reset) modelReset();
         else modelStep();
         #1;
         checkOutput();
      end
   endtask

   initial begin
      logic pgRand;
      assertCount = 0;
      failCount   = 0;
      modelReset();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      $display("[TB] start");

      // Reset held with all inputs toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         applyStimulus(i[0], ~i[0], i[1], ~i[1], i[0]);
         runCycles(1);
      end
      checkVal("rst_pg_out", busIf.PG_OUT, 1'b0);
      checkVal("rst_count",  busIf.COUNT,  '0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1, 0, 0, 0, 0);
      runCycles(3);
      checkVal("idle_busy", busIf.BUSY, 1'b0);

      // Normal fill: hold at cycle 1, valve at cycle 3, level trips at cycle 6
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(1);
      checkVal("s2_hold", busIf.PG_OUT, 1'b1);
      checkVal("s2_ev_settling", busIf.EV, 1'b0);
      runCycles(2);
      checkVal("s2_ev_open", busIf.EV, 1'b1);
      runCycles(2);
      applyStimulus(1, 1, 1, 0, 0);
      runCycles(1);
      checkVal("s2_ev_closed", busIf.EV, 1'b0);
      checkVal("s2_released", busIf.PG_OUT, 1'b0);
      checkVal("s2_count", busIf.COUNT, 8'd1);
      applyStimulus(1, 0, 0, 0, 0);
      runCycles(2);
      checkVal("s2_still_release", busIf.BUSY, 1'b1);
      runCycles(1);
      checkVal("s2_idle", busIf.BUSY, 1'b0);

      // Timeout after 10 valve-open cycles, then acknowledge
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(3);
      runCycles(9);
      checkVal("s3_no_alarm_yet", busIf.ALARM, 1'b0);
      runCycles(1);
      checkVal("s3_alarm", busIf.ALARM, 1'b1);
      checkVal("s3_alarm_ev", busIf.EV, 1'b0);
      checkVal("s3_alarm_hold", busIf.PG_OUT, 1'b1);
      applyStimulus(1, 1, 0, 0, 1);
      runCycles(1);
      checkVal("s3_ack_release", busIf.ALARM, 1'b0);
      checkVal("s3_count_kept", busIf.COUNT, 8'd1);
      applyStimulus(1, 0, 0, 0, 0);
      runCycles(3);

      // Pause with ST low, then level trips on the last allowed cycle
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(6);
      applyStimulus(0, 1, 0, 0, 0);
      runCycles(5);
      checkVal("s4_paused_ev", busIf.EV, 1'b0);
      checkVal("s4_paused_hold", busIf.PG_OUT, 1'b1);
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(6);
      checkVal("s4_resumed_ev", busIf.EV, 1'b1);
      applyStimulus(1, 1, 1, 0, 0);
      runCycles(1);
      checkVal("s4_nv_wins", busIf.ALARM, 1'b0);
      checkVal("s4_count", busIf.COUNT, 8'd2);

      // Batch complete, further bottle not held, acknowledge clears count
      applyStimulus(1, 0, 0, 0, 0);
      runCycles(3);
      checkVal("s5_done", busIf.BATCH_DONE, 1'b1);
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(2);
      checkVal("s5_not_held", busIf.PG_OUT, 1'b0);
      applyStimulus(1, 1, 0, 0, 1);
      runCycles(1);
      checkVal("s5_count_clr", busIf.COUNT, 8'd0);
      checkVal("s5_idle", busIf.BUSY, 1'b0);
      applyStimulus(1, 0, 0, 0, 0);
      runCycles(1);

      // Motor running during settle restarts the settle count
      applyStimulus(1, 1, 0, 1, 0);
      runCycles(4);
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(1);
      applyStimulus(1, 1, 0, 1, 0);
      runCycles(1);
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(1);
      checkVal("s6_settle_ev", busIf.EV, 1'b0);
      runCycles(1);
      checkVal("s6_fill_ev", busIf.EV, 1'b1);
      applyStimulus(1, 1, 1, 0, 0);
      runCycles(1);
      applyStimulus(1, 0, 0, 0, 0);
      runCycles(3);

      // Asynchronous reset between edges in the middle of a fill
      applyStimulus(1, 1, 0, 0, 0);
      runCycles(3);
      checkVal("s6_pre_rst_ev", busIf.EV, 1'b1);
      checkVal("s6_pre_rst_count", busIf.COUNT, 8'd1);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkVal("s6_async_ev", busIf.EV, 1'b0);
      checkVal("s6_async_pg", busIf.PG_OUT, 1'b0);
      checkVal("s6_async_count", busIf.COUNT, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      runCycles(1);

      // Randomized run against the reference model
      pgRand = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) pgRand = ~pgRand;
         applyStimulus($urandom_range(0, 9) != 0, pgRand,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 5) == 0);
         runCycles(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
